// File: rtl/thumb_fetch_sequencer.sv
// Thumb fetch sequencer: buffers one fetch word and issues it to the decoder, either as one
// ARM instruction or as two transcoded Thumb halfwords.
// Optional feature macro: THUMB_BL_FUSE_EN enables BL prefix/suffix fusion and orphan reporting.
module thumb_fetch_sequencer #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              thumb_mode,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_pc,
    input  logic              ifq_valid,
    output logic              ifq_ready,
    input  logic [31:0]       ifq_data,
    input  logic [ADDR_W-1:0] ifq_addr,
    output logic [15:0]       xc_thumb,
    input  logic [31:0]       xc_arm,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [31:0]       dec_code,
    output logic [ADDR_W-1:0] dec_pc,
    output logic              dec_thumb_bl,
    output logic              err_orphan_bl
);

    typedef enum logic [1:0] {S_EMPTY, S_LO, S_HI, S_ARM} state_t;

    state_t            state_q, state_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              skip_lo_q, skip_lo_d;

    logic              bl_pend_q;
    logic [10:0]       hi11_q;
    logic [ADDR_W-1:0] blpc_q;

    logic              in_thumb, last_item, hw_prefix, hw_suffix;
    logic              orphan_hw, prefix_take, fuse_beat, issue;
    logic              fire, consume, accept, arm_orphan;
    logic [15:0]       hw;
    logic [ADDR_W-1:0] hw_pc;
    logic [21:0]       bl_off;
    logic              unused_flush_pc;

    // Only bit 1 of the restart PC matters: it picks the start halfword of the next word.
    assign unused_flush_pc = ^{flush_pc[ADDR_W-1:2], flush_pc[0]};

    assign in_thumb  = (state_q == S_LO) || (state_q == S_HI);
    assign last_item = (state_q == S_HI) || (state_q == S_ARM);
    assign hw        = (state_q == S_HI) ? buf_q[31:16] : buf_q[15:0];
    assign hw_pc     = (state_q == S_HI) ? addr_q + ADDR_W'(2) : addr_q;
    assign xc_thumb  = in_thumb ? hw : 16'h0000;

`ifdef THUMB_BL_FUSE_EN
    assign hw_prefix = in_thumb && (hw[15:11] == 5'b11110);
    assign hw_suffix = in_thumb && (hw[15:11] == 5'b11111);
`else
    assign hw_prefix = 1'b0;
    assign hw_suffix = 1'b0;
`endif

    // A pending prefix followed by anything but a suffix is dropped; that cycle issues nothing.
    assign orphan_hw   = in_thumb && bl_pend_q && !hw_suffix;
    assign prefix_take = !flush && hw_prefix && !bl_pend_q;
    assign fuse_beat   = in_thumb && bl_pend_q && hw_suffix;
    assign issue       = (state_q == S_ARM) || (in_thumb && !orphan_hw && !hw_prefix);

    assign dec_valid  = issue && !flush;
    assign fire       = dec_valid && dec_ready;
    assign consume    = fire || prefix_take;
    assign ifq_ready  = (state_q == S_EMPTY) || (consume && last_item);
    assign accept     = ifq_valid && ifq_ready && !flush;
    assign arm_orphan = accept && !thumb_mode && (bl_pend_q || prefix_take);

    assign bl_off        = {hi11_q, hw[10:0]};
    assign dec_thumb_bl  = fuse_beat;
    assign err_orphan_bl = !flush && (orphan_hw || arm_orphan);

    // Decoder-side instruction and PC selection.
    always_comb begin
        dec_code = 32'h0;
        dec_pc   = '0;
        case (state_q)
            S_ARM: begin
                dec_code = buf_q;
                dec_pc   = addr_q;
            end
            S_LO, S_HI: begin
                if (fuse_beat) begin
                    dec_code = {8'hEB, {2{bl_off[21]}}, bl_off};
                    dec_pc   = blpc_q;
                end else begin
                    dec_code = xc_arm;
                    dec_pc   = hw_pc;
                end
            end
            default: ;
        endcase
    end

    // Buffer and state sequencing: consume advances, accept reloads, flush overrides both.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        addr_d    = addr_q;
        skip_lo_d = skip_lo_q;
        if (flush) begin
            state_d   = S_EMPTY;
            skip_lo_d = flush_pc[1];
        end else begin
            if (consume) begin
                case (state_q)
                    S_LO:        state_d = S_HI;
                    S_HI, S_ARM: state_d = S_EMPTY;
                    default:     ;
                endcase
            end
            if (accept) begin
                buf_d     = ifq_data;
                addr_d    = ifq_addr;
                skip_lo_d = 1'b0;
                if (!thumb_mode)    state_d = S_ARM;
                else if (skip_lo_q) state_d = S_HI;
                else                state_d = S_LO;
            end
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EMPTY;
            buf_q     <= 32'h0;
            addr_q    <= '0;
            skip_lo_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            addr_q    <= addr_d;
            skip_lo_q <= skip_lo_d;
        end
    end

`ifdef THUMB_BL_FUSE_EN
    logic              bl_pend_d;
    logic [10:0]       hi11_d;
    logic [ADDR_W-1:0] blpc_d;

    // Pending-BL tracking: capture prefix, clear on fused fire, orphan or flush.
    always_comb begin
        bl_pend_d = bl_pend_q;
        hi11_d    = hi11_q;
        blpc_d    = blpc_q;
        if (flush) begin
            bl_pend_d = 1'b0;
        end else begin
            if (prefix_take) begin
                bl_pend_d = 1'b1;
                hi11_d    = hw[10:0];
                blpc_d    = hw_pc;
            end
            if (orphan_hw || (fuse_beat && fire) || arm_orphan)
                bl_pend_d = 1'b0;
        end
    end

    // Pending-BL registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bl_pend_q <= 1'b0;
            hi11_q    <= 11'h0;
            blpc_q    <= '0;
        end else begin
            bl_pend_q <= bl_pend_d;
            hi11_q    <= hi11_d;
            blpc_q    <= blpc_d;
        end
    end
`else
    assign bl_pend_q = 1'b0;
    assign hi11_q    = 11'h0;
    assign blpc_q    = '0;
`endif

endmodule

// File: tb/tb_thumb_fetch_sequencer.sv
// Directed testbench for thumb_fetch_sequencer; fusion checks run when THUMB_BL_FUSE_EN is defined.
module tb_thumb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, thumb_mode, flush, ifq_valid, dec_ready;
    logic [31:0] flush_pc, ifq_data, ifq_addr, dec_pc;
    logic        ifq_ready, dec_valid, dec_thumb_bl, err_orphan_bl;
    logic [15:0] xc_thumb;
    logic [31:0] xc_arm, dec_code;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Stand-in transcoder: easily recognisable, distinct per halfword.
    assign xc_arm = {~xc_thumb, xc_thumb};

    thumb_fetch_sequencer #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .thumb_mode(thumb_mode), .flush(flush), .flush_pc(flush_pc),
        .ifq_valid(ifq_valid), .ifq_ready(ifq_ready), .ifq_data(ifq_data), .ifq_addr(ifq_addr),
        .xc_thumb(xc_thumb), .xc_arm(xc_arm), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_code(dec_code), .dec_pc(dec_pc), .dec_thumb_bl(dec_thumb_bl),
        .err_orphan_bl(err_orphan_bl)
    );

    function automatic logic [31:0] xc(input logic [15:0] h);
        return {~h, h};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 64'(dec_valid), 64'd0);
        chk({tag, "_ready"}, 64'(ifq_ready), 64'd1);
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] code, input logic [31:0] pc,
                            input logic bl, input logic rdy);
        chk({tag, "_valid"}, 64'(dec_valid), 64'd1);
        chk({tag, "_code"},  64'(dec_code),  64'(code));
        chk({tag, "_pc"},    64'(dec_pc),    64'(pc));
        chk({tag, "_bl"},    64'(dec_thumb_bl), 64'(bl));
        chk({tag, "_ifqrdy"}, 64'(ifq_ready), 64'(rdy));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, 64'(dec_valid), 64'd0);
        chk({tag, "_ready"}, 64'(ifq_ready), 64'd1);
        chk({tag, "_code"},  64'(dec_code),  64'd0);
        chk({tag, "_pc"},    64'(dec_pc),    64'd0);
        chk({tag, "_xc"},    64'(xc_thumb),  64'd0);
        chk({tag, "_bl"},    64'(dec_thumb_bl), 64'd0);
        chk({tag, "_err"},   64'(err_orphan_bl), 64'd0);
    endtask

    initial begin
        rst_n = 1'b1; thumb_mode = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        ifq_valid = 1'b0; ifq_data = 32'h0; ifq_addr = 32'h0; dec_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset("reset");
        tick(); tick();
        rst_n = 1'b1;
        #1;

        // Thumb word, both halves in order
        thumb_mode = 1'b1; dec_ready = 1'b1;
        ifq_valid = 1'b1; ifq_data = 32'h1C48_3001; ifq_addr = 32'h100;
        #1 chk("t1_accept_rdy", 64'(ifq_ready), 64'd1);
        tick(); ifq_valid = 1'b0; #1;
        chk("t1_xc_lo", 64'(xc_thumb), 64'h3001);
        chk_beat("t1_lo", xc(16'h3001), 32'h100, 1'b0, 1'b0);
        tick();
        chk("t1_xc_hi", 64'(xc_thumb), 64'h1C48);
        chk_beat("t1_hi", xc(16'h1C48), 32'h102, 1'b0, 1'b1);
        tick();
        chk_idle("t1_empty");

        // ARM words streamed back to back
        thumb_mode = 1'b0;
        ifq_valid = 1'b1; ifq_data = 32'hE3A0_0001; ifq_addr = 32'h0;
        tick(); ifq_data = 32'hE280_0001; ifq_addr = 32'h4; #1;
        chk_beat("t2_w0", 32'hE3A0_0001, 32'h0, 1'b0, 1'b1);
        tick(); ifq_valid = 1'b0; #1;
        chk_beat("t2_w1", 32'hE280_0001, 32'h4, 1'b0, 1'b1);
        tick();
        chk_idle("t2_empty");

        // Prefix/suffix word
        thumb_mode = 1'b1;
        ifq_valid = 1'b1; ifq_data = 32'hF800_F000; ifq_addr = 32'h600;
        tick(); ifq_valid = 1'b0; #1;
`ifdef THUMB_BL_FUSE_EN
        chk("t3_prefix_valid", 64'(dec_valid), 64'd0);
        chk("t3_prefix_err", 64'(err_orphan_bl), 64'd0);
        tick();
        chk_beat("t3_fused", 32'hEB00_0000, 32'h600, 1'b1, 1'b1);
        tick();
        chk_idle("t3_empty");

        // Prefix in HI, suffix in the next word's LO
        ifq_valid = 1'b1; ifq_data = 32'hF000_2005; ifq_addr = 32'h200;
        tick(); ifq_data = 32'h3003_F802; ifq_addr = 32'h204; #1;
        chk_beat("t4_lo", xc(16'h2005), 32'h200, 1'b0, 1'b0);
        tick();
        chk("t4_prefix_valid", 64'(dec_valid), 64'd0);
        chk("t4_prefix_rdy", 64'(ifq_ready), 64'd1);
        tick(); ifq_valid = 1'b0; #1;
        chk_beat("t4_fused", 32'hEB00_0002, 32'h202, 1'b1, 1'b0);
        tick();
        chk_beat("t4_hi", xc(16'h3003), 32'h206, 1'b0, 1'b1);
        tick();
        chk_idle("t4_empty");

        // Same, but the following halfword is not a suffix
        ifq_valid = 1'b1; ifq_data = 32'hF000_2005; ifq_addr = 32'h200;
        tick(); ifq_data = 32'h3003_2001; ifq_addr = 32'h204;
        tick(); tick(); ifq_valid = 1'b0; #1;
        chk("t4b_orphan_valid", 64'(dec_valid), 64'd0);
        chk("t4b_orphan_err", 64'(err_orphan_bl), 64'd1);
        tick();
        chk("t4b_err_clear", 64'(err_orphan_bl), 64'd0);
        chk_beat("t4b_lo", xc(16'h2001), 32'h204, 1'b0, 1'b0);
        tick();
        chk_beat("t4b_hi", xc(16'h3003), 32'h206, 1'b0, 1'b1);
        tick();
        chk_idle("t4b_empty");
`else
        chk_beat("t3_plain_lo", xc(16'hF000), 32'h600, 1'b0, 1'b0);
        chk("t3_plain_lo_err", 64'(err_orphan_bl), 64'd0);
        tick();
        chk_beat("t3_plain_hi", xc(16'hF800), 32'h602, 1'b0, 1'b1);
        chk("t3_plain_hi_err", 64'(err_orphan_bl), 64'd0);
        tick();
        chk_idle("t3_empty");
`endif

        // Flush with a simultaneous word: word dropped, restart on the HI half
        flush = 1'b1; flush_pc = 32'h302;
        ifq_valid = 1'b1; ifq_data = 32'h5555_AAAA; ifq_addr = 32'h400;
        #1 chk("t5_flush_valid", 64'(dec_valid), 64'd0);
        tick(); flush = 1'b0; flush_pc = 32'h0; ifq_valid = 1'b0; #1;
        chk_idle("t5_dropped");
        ifq_valid = 1'b1; ifq_data = 32'h4411_2233; ifq_addr = 32'h300;
        tick(); ifq_valid = 1'b0; #1;
        chk("t5_xc", 64'(xc_thumb), 64'h4411);
        chk_beat("t5_hi", xc(16'h4411), 32'h302, 1'b0, 1'b1);
        tick();
        chk_idle("t5_empty");

        // Decoder stall in LO, then async reset mid-stream
        dec_ready = 1'b0;
        ifq_valid = 1'b1; ifq_data = 32'h2222_1111; ifq_addr = 32'h500;
        tick(); ifq_valid = 1'b0; #1;
        for (int i = 0; i < 5; i++) begin
            chk_beat("t6_hold", xc(16'h1111), 32'h500, 1'b0, 1'b0);
            tick();
        end
        dec_ready = 1'b1; #1;
        chk("t6_release_rdy", 64'(ifq_ready), 64'd0);
        tick();
        chk_beat("t6_hi", xc(16'h2222), 32'h502, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #1 chk_reset("t6_midreset");
        tick(); rst_n = 1'b1; #1;

        // Flush drops dec_valid in the same cycle and empties the buffer
        ifq_valid = 1'b1; ifq_data = 32'h6666_7777; ifq_addr = 32'h700;
        tick(); ifq_valid = 1'b0; #1;
        chk_beat("t7_lo", xc(16'h7777), 32'h700, 1'b0, 1'b0);
        flush = 1'b1; #1;
        chk("t7_flush_drop", 64'(dec_valid), 64'd0);
        tick(); flush = 1'b0; #1;
        chk_idle("t7_empty");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
